// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the CPU step controller: FSM encoding and the
// saturating step counter.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_MANUAL = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int STEP_CNT_W = 16;
  localparam logic [STEP_CNT_W-1:0] STEP_CNT_MAX = '1;

  function automatic logic [STEP_CNT_W-1:0] sat_inc(input logic [STEP_CNT_W-1:0] v);
    return (v == STEP_CNT_MAX) ? v : v + STEP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/cpu_step_ctrl_sync_debounce.sv
// Two-flop synchronizer followed by a counter debouncer for one raw board input.
// The stable value flips only after the synced input has differed for DEBOUNCE_CYCLES cycles.
module sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_CNT_W        = 20
) (
  input  logic mclk,
  input  logic clr,
  input  logic async_in,
  output logic stable_out
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                sync1_q, sync2_q;
  logic                stable_q, stable_d;
  logic [DB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
      end else begin
        cnt_d = cnt_q + DB_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge mclk or negedge clr) begin
    if (!clr) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= async_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_out = stable_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable generator: manual single-step, divided free-run, and a
// sticky halt requested by the core.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_CNT_W        = 20,
  parameter int RUN_DIV_LOG2    = 26
) (
  input  logic                  mclk,
  input  logic                  clr,
  input  logic                  btn_step,
  input  logic                  sw_run,
  input  logic                  halt,
  output logic                  cpu_en,
  output logic                  run_mode,
  output logic                  halted,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  logic btn_db, sw_db;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_btn_db (
    .mclk      (mclk),
    .clr       (clr),
    .async_in  (btn_step),
    .stable_out(btn_db)
  );

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .DB_CNT_W       (DB_CNT_W)
  ) u_sw_db (
    .mclk      (mclk),
    .clr       (clr),
    .async_in  (sw_run),
    .stable_out(sw_db)
  );

  state_e                  state_q, state_d;
  logic                    btn_prev_q, btn_prev_d;
  logic                    req_q, req_d;
  logic [RUN_DIV_LOG2-1:0] presc_q, presc_d;
  logic                    cpu_en_q, cpu_en_d;
  logic [STEP_CNT_W-1:0]   step_cnt_q, step_cnt_d;

  // The prescaler only counts while RUN persists, so entering RUN always starts it from zero.
  always_comb begin
    btn_prev_d = btn_db;
    req_d      = btn_db & ~btn_prev_q;
    state_d    = state_q;
    presc_d    = '0;
    cpu_en_d   = 1'b0;
    step_cnt_d = cpu_en_q ? sat_inc(step_cnt_q) : step_cnt_q;
    if (halt) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_MANUAL: begin
          if (sw_db) state_d = ST_RUN;
          else       cpu_en_d = req_q;
        end
        ST_RUN: begin
          if (!sw_db) begin
            state_d = ST_MANUAL;
          end else begin
            presc_d  = presc_q + RUN_DIV_LOG2'(1);
            cpu_en_d = &presc_q;
          end
        end
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_MANUAL;
      endcase
    end
  end

  always_ff @(posedge mclk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_MANUAL;
      btn_prev_q <= 1'b0;
      req_q      <= 1'b0;
      presc_q    <= '0;
      cpu_en_q   <= 1'b0;
      step_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      btn_prev_q <= btn_prev_d;
      req_q      <= req_d;
      presc_q    <= presc_d;
      cpu_en_q   <= cpu_en_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign cpu_en   = cpu_en_q;
  assign run_mode = (state_q == ST_RUN);
  assign halted   = (state_q == ST_HALTED);
  assign step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl with DEBOUNCE_CYCLES=4 and RUN_DIV_LOG2=3:
// a per-cycle vector table for stepping, plus hand sequences for run, halt, saturation and reset.
module tb_cpu_step_ctrl;

  logic        mclk     = 1'b0;
  logic        clr      = 1'b0;
  logic        btn_step = 1'b0;
  logic        sw_run   = 1'b0;
  logic        halt     = 1'b0;
  logic        cpu_en;
  logic        run_mode;
  logic        halted;
  logic [15:0] step_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        btn;
    logic        sw;
    logic        hlt;
    logic        exp_en;
    logic        exp_run;
    logic        exp_halted;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  cpu_step_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .DB_CNT_W       (3),
    .RUN_DIV_LOG2   (3)
  ) dut (
    .mclk    (mclk),
    .clr     (clr),
    .btn_step(btn_step),
    .sw_run  (sw_run),
    .halt    (halt),
    .cpu_en  (cpu_en),
    .run_mode(run_mode),
    .halted  (halted),
    .step_cnt(step_cnt)
  );

  always #5 mclk = ~mclk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic applyStimulus(input logic b, input logic s, input logic h);
    btn_step = b;
    sw_run   = s;
    halt     = h;
    @(posedge mclk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input logic e_en,
                             input logic e_run, input logic e_halted, input logic [15:0] e_cnt);
    checks++;
    if (cpu_en !== e_en || run_mode !== e_run || halted !== e_halted || step_cnt !== e_cnt) begin
      errors++;
      $display("[TB] FAIL %s[%0d]: got en=%0b run=%0b halted=%0b cnt=%h, want en=%0b run=%0b halted=%0b cnt=%h",
               name, idx, cpu_en, run_mode, halted, step_cnt, e_en, e_run, e_halted, e_cnt);
    end
  endtask

  task automatic addVec(input logic b, input logic s, input logic h, input logic e_en,
                        input logic e_run, input logic e_halted, input logic [15:0] e_cnt);
    vec_t v;
    v.btn = b; v.sw = s; v.hlt = h;
    v.exp_en = e_en; v.exp_run = e_run; v.exp_halted = e_halted; v.exp_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  // Outputs must clear without waiting for a clock edge.
  task automatic doReset(input logic hold_btn);
    clr      = 1'b0;
    btn_step = hold_btn;
    sw_run   = 1'b0;
    halt     = 1'b0;
    #2;
    checkOutput("async_clr", 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge mclk);
    #1;
    clr = 1'b1;
  endtask

  initial begin
    logic        exp_en;
    logic        exp_run;
    logic        exp_halted;
    logic [15:0] model_cnt;
    int          pulses;
    logic        bounce[8];

    bounce = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // Clean press: pulse at vector 7, count visible one cycle later, release is silent.
    for (int i = 0; i < 20; i++) addVec(1'b1, 1'b0, 1'b0, (i == 7), 1'b0, 1'b0, (i >= 8) ? 16'd1 : 16'd0);
    for (int i = 0; i < 12; i++) addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    // Bouncing button: nothing until the level holds, then one pulse 7 cycles after it settles.
    for (int j = 0; j < 8; j++)  addVec(bounce[j], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    for (int j = 8; j < 28; j++) addVec(1'b1, 1'b0, 1'b0, (j == 15), 1'b0, 1'b0, (j >= 16) ? 16'd2 : 16'd1);
    for (int j = 0; j < 10; j++) addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);

    repeat (2) @(posedge mclk);
    #1;
    checkOutput("reset_init", 0, 1'b0, 1'b0, 1'b0, 16'h0000);
    clr = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].btn, vecs[i].sw, vecs[i].hlt);
      checkOutput("vec", i, vecs[i].exp_en, vecs[i].exp_run, vecs[i].exp_halted, vecs[i].exp_cnt);
    end

    // Free run: RUN after 6 cycles, pulses every 8 from cycle 14, switch off at cycle 87.
    doReset(1'b0);
    pulses = 0;
    for (int c = 0; c <= 110; c++) begin
      applyStimulus(1'b0, (c < 87), 1'b0);
      exp_en  = (c >= 14) && (c <= 86) && ((c - 14) % 8 == 0);
      exp_run = (c >= 6) && (c <= 92);
      checkOutput("run", c, exp_en, exp_run, 1'b0, 16'(pulses));
      if (exp_en) pulses++;
    end
    checkOutput("run_total", 0, 1'b0, 1'b0, 1'b0, 16'd10);

    // Halt on the cycle of the second scheduled pulse; halt is sticky and blocks steps.
    doReset(1'b0);
    for (int c = 0; c <= 70; c++) begin
      applyStimulus((c >= 46), 1'b1, (c == 22));
      exp_en     = (c == 14);
      exp_run    = (c >= 6) && (c < 22);
      exp_halted = (c >= 22);
      checkOutput("halt", c, exp_en, exp_run, exp_halted, (c >= 15) ? 16'd1 : 16'd0);
    end
    doReset(1'b0);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("post_halt_reset", c, 1'b0, 1'b0, 1'b0, 16'h0000);
    end

    // Saturation: preload near the top, then free-run past it.
    doReset(1'b0);
    force dut.step_cnt_q = 16'hFFFC;
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    release dut.step_cnt_q;
    checkOutput("sat_preload", 0, 1'b0, 1'b0, 1'b0, 16'hFFFC);
    model_cnt = 16'hFFFC;
    for (int c = 0; c <= 55; c++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      exp_en = (c >= 14) && ((c - 14) % 8 == 0);
      checkOutput("sat", c, exp_en, (c >= 6), 1'b0, model_cnt);
      if (exp_en && model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
    end

    // Reset in the middle of a debounce, button still held through release.
    doReset(1'b0);
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("pre_press", c, (c == 7), 1'b0, 1'b0, (c >= 8) ? 16'd1 : 16'd0);
    end
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("pre_release", c, 1'b0, 1'b0, 1'b0, 16'd1);
    end
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("mid_debounce", c, 1'b0, 1'b0, 1'b0, 16'd1);
    end
    doReset(1'b1);
    for (int c = 0; c <= 20; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("redebounce", c, (c == 7), 1'b0, 1'b0, (c >= 8) ? 16'd1 : 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
